// File: rtl/accum_delta_decoder_pkg.sv
// Shared definitions for the delta decoder and its skid buffer.
//   - skid_state_t : occupancy of the 2-entry output buffer (2-bit encoding)
//   - DEF_WIDTH    : default datapath width, common with the accumulator
//   - DEF_CNT_W    : default width of the accepted-sample counter
package accum_delta_decoder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/accum_delta_decoder_skid_buf.sv
// delta_skid_buf: 2-entry FIFO-ordered valid/ready buffer.
//
// Handshake: a push happens on a cycle where push_valid is high and the
// buffer is not full (state != TWO); a pop happens where pop_valid and
// pop_ready are both high. pop_valid/pop_data come straight from
// registered state, and the full/not-full decision also depends only on
// the state register, so no combinational path crosses the buffer.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous flush; drops all entries, a same-cycle push
//                becomes the only entry
//   push_valid   producer offers push_data
//   push_data    PAYLOAD_W payload
//   pop_valid    head entry valid
//   pop_ready    consumer takes the head
//   pop_data     head entry payload
//   state        current occupancy (EMPTY/ONE/TWO), exported for the
//                parent's ready logic and for observation
module delta_skid_buf
    import accum_delta_decoder_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push_valid,
    input  logic [PAYLOAD_W-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [PAYLOAD_W-1:0] pop_data,
    output logic [1:0]           state
);

    skid_state_t          state_q;
    skid_state_t          state_d;
    logic [PAYLOAD_W-1:0] head_q;
    logic [PAYLOAD_W-1:0] tail_q;
    logic                 push;
    logic                 pop;
    logic                 load_head;
    logic                 load_tail;
    logic                 head_from_tail;

    assign push      = push_valid && (state_q != SKID_TWO);
    assign pop_valid = (state_q != SKID_EMPTY);
    assign pop       = pop_valid && pop_ready;
    assign pop_data  = head_q;
    assign state     = state_q;

    // Next-state and data-move decode. A flush overrides the normal
    // transitions; the pop in that cycle still completes because the
    // consumer sampled the old head before the edge.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        if (flush) begin
            if (push) begin
                state_d   = SKID_ONE;
                load_head = 1'b1;
            end else begin
                state_d = SKID_EMPTY;
            end
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        state_d   = SKID_ONE;
                        load_head = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new entry replaces it.
                        load_head = 1'b1;
                    end else if (push) begin
                        state_d   = SKID_TWO;
                        load_tail = 1'b1;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (pop) begin
                        state_d        = SKID_ONE;
                        head_from_tail = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head) begin
                head_q <= push_data;
            end else if (head_from_tail) begin
                head_q <= tail_q;
            end
            if (load_tail) begin
                tail_q <= push_data;
            end
        end
    end

endmodule

// File: rtl/accum_delta_decoder.sv
// accum_delta_decoder: inverse of the running-sum accumulator.
// Emits out[n] = in[n] - in[n-1] (mod 2^WIDTH) with in[-1] = 0, through a
// 2-entry skid buffer so in_ready depends only on registered state.
//
// Handshake: input transfer when in_valid && in_ready; output transfer
// when out_valid && out_ready. out_data/out_first hold steady while
// out_valid && !out_ready.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous stream restart (prev=0, buffer flushed,
//                counter zeroed); a same-cycle push is delta'd against 0
//   in_valid     producer has a sample
//   in_ready     block can take a sample
//   in_data      accumulated value
//   out_valid    head of the buffer is valid
//   out_ready    consumer takes the head
//   out_data     difference value
//   out_first    head is the first delta since reset or clr
//   sample_cnt   samples accepted since reset or clr (wraps)
module accum_delta_decoder
    import accum_delta_decoder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_first,
    output logic [CNT_W-1:0] sample_cnt
);

    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_pending_q;
    logic [1:0]       skid_state;
    logic             push;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] delta;
    logic             first_flag;
    logic [WIDTH:0]   head_payload;

    assign in_ready = (skid_state != SKID_TWO);
    assign push     = in_valid && in_ready;

    // A clr cycle restarts the stream, so its sample is measured from 0
    // and is always the first of the new stream.
    assign base       = clr ? '0 : prev_q;
    assign delta      = in_data - base;
    assign first_flag = clr ? 1'b1 : first_pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q          <= '0;
            cnt_q           <= '0;
            first_pending_q <= 1'b1;
        end else if (push) begin
            prev_q          <= in_data;
            cnt_q           <= clr ? CNT_W'(1) : cnt_q + CNT_W'(1);
            first_pending_q <= 1'b0;
        end else if (clr) begin
            prev_q          <= '0;
            cnt_q           <= '0;
            first_pending_q <= 1'b1;
        end
    end

    delta_skid_buf #(
        .PAYLOAD_W (WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (clr),
        .push_valid (in_valid),
        .push_data  ({first_flag, delta}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_payload),
        .state      (skid_state)
    );

    assign out_first  = head_payload[WIDTH];
    assign out_data   = head_payload[WIDTH-1:0];
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_accum_delta_decoder.sv
module tb_accum_delta_decoder;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic [15:0] sample_cnt;

  accum_delta_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_first  (out_first),
    .sample_cnt (sample_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  // Entries are {first, delta}; the queue length is the buffer occupancy.
  logic [32:0] m_q[$];
  logic [32:0] pop_log[$];
  logic [31:0] rt_exp[$];
  logic [31:0] m_prev;
  logic [15:0] m_cnt;
  logic        m_first;
  logic        rt_mode;
  logic        last_push;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev  = '0;
    m_cnt   = '0;
    m_first = 1'b1;
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(m_q[0][31:0]));
      chk("out_first", 64'(out_first), 64'(m_q[0][32]));
    end
    chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
  endtask

  // One clock cycle: drive inputs (called just after a falling edge),
  // advance the model by the same transfer rules, then compare on the
  // next falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
    logic push;
    logic pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    push = v && (m_q.size() < 2);
    pop  = r && (m_q.size() > 0);
    if (pop && rt_mode) begin
      if (rt_exp.size() == 0) chk("rt_extra_output", 64'(out_data), 64'hDEAD);
      else chk("rt_data", 64'(out_data), 64'(rt_exp.pop_front()));
    end
    if (pop) pop_log.push_back(m_q[0]);
    if (c) begin
      m_q.delete();
      if (push) begin
        m_q.push_back({1'b1, d});
        m_prev  = d;
        m_cnt   = 16'd1;
        m_first = 1'b0;
      end else begin
        m_prev  = '0;
        m_cnt   = '0;
        m_first = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_first, d - m_prev});
        m_prev  = d;
        m_cnt   = m_cnt + 16'd1;
        m_first = 1'b0;
      end
    end
    last_push = push;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  // Reset pulsed between edges; outputs must drop without a clock.
  task automatic async_reset_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_first", 64'(out_first), 64'd0);
    chk("arst_cnt", 64'(sample_cnt), 64'd0);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] acc;
    logic [31:0] x;
    logic        have;
    int          idx;

    total     = 0;
    bad       = 0;
    rt_mode   = 1'b0;
    last_push = 1'b0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_first", 64'(out_first), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
    rst_n = 1'b1;
    check_all();

    // Basic decode
    pop_log.delete();
    step(1'b1, 32'd5, 1'b1, 1'b0);
    step(1'b1, 32'd12, 1'b1, 1'b0);
    step(1'b1, 32'd12, 1'b1, 1'b0);
    step(1'b1, 32'd7, 1'b1, 1'b0);
    idle(2);
    chk("basic_n", 64'(pop_log.size()), 64'd4);
    chk("basic_0", 64'(pop_log[0]), {31'd0, 1'b1, 32'd5});
    chk("basic_1", 64'(pop_log[1]), {31'd0, 1'b0, 32'd7});
    chk("basic_2", 64'(pop_log[2]), {31'd0, 1'b0, 32'd0});
    chk("basic_3", 64'(pop_log[3]), {31'd0, 1'b0, 32'hFFFFFFFB});
    chk("basic_cnt", 64'(m_cnt), 64'd4);

    // Wrap-around
    step(1'b0, 32'd0, 1'b1, 1'b1);
    pop_log.delete();
    step(1'b1, 32'hFFFFFFF0, 1'b1, 1'b0);
    step(1'b1, 32'h00000010, 1'b1, 1'b0);
    idle(2);
    chk("wrap_n", 64'(pop_log.size()), 64'd2);
    chk("wrap_0", 64'(pop_log[0]), {31'd0, 1'b1, 32'hFFFFFFF0});
    chk("wrap_1", 64'(pop_log[1]), {31'd0, 1'b0, 32'h00000020});

    // Backpressure
    step(1'b0, 32'd0, 1'b1, 1'b1);
    pop_log.delete();
    step(1'b1, 32'd10, 1'b0, 1'b0);
    step(1'b1, 32'd30, 1'b0, 1'b0);
    chk("bp_full", 64'(m_q.size()), 64'd2);
    step(1'b1, 32'd60, 1'b0, 1'b0);
    step(1'b1, 32'd60, 1'b0, 1'b0);
    chk("bp_head", 64'(m_q[0]), {31'd0, 1'b1, 32'd10});
    step(1'b1, 32'd60, 1'b1, 1'b0);
    step(1'b1, 32'd60, 1'b1, 1'b0);
    idle(3);
    chk("bp_n", 64'(pop_log.size()), 64'd3);
    chk("bp_0", 64'(pop_log[0][31:0]), 64'd10);
    chk("bp_1", 64'(pop_log[1][31:0]), 64'd20);
    chk("bp_2", 64'(pop_log[2][31:0]), 64'd30);

    // Clear with simultaneous push
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'd100, 1'b1, 1'b0);
    step(1'b1, 32'd150, 1'b1, 1'b0);
    step(1'b1, 32'd40, 1'b1, 1'b1);
    chk("clr_n", 64'(m_q.size()), 64'd1);
    chk("clr_head", 64'(m_q[0]), {31'd0, 1'b1, 32'd40});
    chk("clr_cnt", 64'(m_cnt), 64'd1);
    pop_log.delete();
    step(1'b1, 32'd45, 1'b1, 1'b0);
    idle(2);
    chk("clr_next", 64'(pop_log[1]), {31'd0, 1'b0, 32'd5});

    // Asynchronous reset with the buffer full
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'd3, 1'b0, 1'b0);
    step(1'b1, 32'd8, 1'b0, 1'b0);
    async_reset_pulse();
    pop_log.delete();
    step(1'b1, 32'd9, 1'b1, 1'b0);
    idle(2);
    chk("arst_next", 64'(pop_log[0]), {31'd0, 1'b1, 32'd9});

    // Random traffic including occasional clr
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    end

    // Round trip: accumulate random values, decoder must return them
    step(1'b0, 32'd0, 1'b1, 1'b1);
    rt_exp.delete();
    rt_mode = 1'b1;
    acc  = '0;
    idx  = 0;
    have = 1'b0;
    x    = '0;
    for (int cyc = 0; cyc < 20000 && idx < 1000; cyc++) begin
      if (!have) begin
        x    = $urandom;
        have = 1'b1;
      end
      step($urandom_range(0, 3) != 0, acc + x, $urandom_range(0, 3) != 0, 1'b0);
      if (last_push) begin
        acc = acc + x;
        rt_exp.push_back(x);
        idx++;
        have = 1'b0;
      end
    end
    idle(4);
    rt_mode = 1'b0;
    chk("rt_accepted", 64'(idx), 64'd1000);
    chk("rt_left", 64'(rt_exp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_delta_decoder.md
# accum_delta_decoder

Inverse of the running-sum accumulator. It accepts a stream of accumulated WIDTH-bit values and emits the per-sample differences out[n] = in[n] − in[n−1] (mod 2^WIDTH), with in[−1] = 0. Feeding an accumulator's outputs through this block recovers the accumulator's original inputs. It sits on the datapath side of the accumulator, between a valid/ready producer and consumer, with a 2-entry output skid buffer so `in_ready` depends only on registered state.

## Interface
- `WIDTH`, 32: data width; all arithmetic is modulo 2^WIDTH.
- `CNT_W`, 16: width of the accepted-sample counter.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous stream restart: previous value becomes 0, skid buffer flushed, counter zeroed.
- `in_valid`  in  1  producer has a sample.
- `in_ready`  out  1  block can take a sample; a transfer occurs when `in_valid && in_ready`.
- `in_data`  in  WIDTH  accumulated value.
- `out_valid`  out  1  head of the skid buffer is valid.
- `out_ready`  in  1  consumer takes the head; a transfer occurs when `out_valid && out_ready`.
- `out_data`  out  WIDTH  difference value.
- `out_first`  out  1  head entry is the first delta after reset or `clr`.
- `sample_cnt`  out  CNT_W  number of samples accepted since reset or `clr`; wraps at 2^CNT_W.

## Operation
- Register `prev` holds the last accepted `in_data`. Reset value is 0.
- On an input transfer: the entry {`in_data` − `prev`, first_flag} is pushed; `prev` ← `in_data`; `sample_cnt` increments.
- first_flag is 1 for the first transfer after reset or `clr`, else 0.
- Subtraction is WIDTH bits with the borrow discarded. Example: 0x00000010 − 0xFFFFFFF0 = 0x00000020.
- Skid buffer states (occupancy):
  - EMPTY: `in_ready`=1, `out_valid`=0.
  - ONE: `in_ready`=1, `out_valid`=1.
  - TWO: `in_ready`=0, `out_valid`=1.
- Transitions, with push = input transfer and pop = output transfer:
  - EMPTY→ONE on push.
  - ONE→TWO on push without pop.
  - ONE→EMPTY on pop without push.
  - ONE→ONE on push and pop together.
  - TWO→ONE on pop.
  - Otherwise hold.
- Order is strictly FIFO. `out_data` and `out_first` always reflect the head entry and stay stable while `out_valid && !out_ready`.
- `clr` has priority over everything else:
  - Without a simultaneous push: buffer → EMPTY, `prev` ← 0, `sample_cnt` ← 0.
  - With a simultaneous push: older entries are discarded. The new sample is delta'd against 0 and becomes the only entry (state ONE, `out_first`=1). `prev` ← `in_data`, `sample_cnt` ← 1.
  - A pop in the `clr` cycle is still a completed transfer of the old head.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_first`=0, `sample_cnt`=0, state EMPTY.

## Timing
- Latency is 1 cycle. A sample accepted at edge k is visible on `out_data` after edge k when the buffer was EMPTY, or after ONE pop was ONE-old entry ahead.
- Throughput is 1 sample/cycle while `out_ready`=1.
- `in_ready` is a pure function of registered state; there is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- `out_valid`/`out_data` are driven from registers; there is no combinational path from the inputs.
- `rst_n` assertion mid-stream clears all state immediately, without waiting for a clock; buffered entries are lost. Deassertion is synchronised externally.

## Structure
- Shared package holds:
  - the skid-state typedef (EMPTY/ONE/TWO, 2-bit encoding);
  - default `WIDTH`/`CNT_W` constants, common with the accumulator.
- One sub-module: `delta_skid_buf`, a 2-entry valid/ready buffer parameterised on payload width. The payload is WIDTH+1 bits (data + first flag), and the sub-module has a flush input driven by `clr`.
- The top level holds `prev`, the subtractor, the first-flag logic and `sample_cnt`.

## Test plan
- **Basic decode:** push 5, 12, 12, 7 with `out_ready`=1 → outputs 5 (first=1), 7, 0, 0xFFFFFFFB; `sample_cnt`=4.
- **Wrap-around:** push 0xFFFFFFF0, 0x00000010 → 0xFFFFFFF0 (first=1), 0x00000020.
- **Backpressure:** hold `out_ready`=0 and offer 10, 30, 60 → 10 and 30 are accepted and `in_ready`=0 after the second. 60 is held on the input; `out_data` stays at 10. Release → 10, 20, 30 in order with no loss.
- **Clear:** after 100, 150 are accepted, assert `clr` together with a push of 40 → buffer holds only 40 with first=1 and `sample_cnt`=1. The next push of 45 yields 5.
- **Async reset:** with the buffer in TWO, pulse `rst_n` low between edges → outputs go to reset values immediately. The next push of 9 yields 9 with first=1.
- **Round trip:** 1000 random values through the accumulator (its reset applied) and then this block, with random `out_ready` → the output sequence equals the input sequence exactly.
